// File: rtl/wram_ctrl_pkg.sv
// Shared types and constants for the 68000 work-RAM controller.
package wram_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_WR_SETUP,
      ST_WR_PULSE,
      ST_WR_HOLD,
      ST_DONE
   } wram_state_t;

   localparam int WRAM_WAIT_DEFAULT = 3;
   localparam int CNT_W             = 4;

endpackage

// File: rtl/wram_wait_cnt.sv
// Loadable down-counter timing the SRAM strobe width; o_tc flags the last strobe cycle.
module wram_wait_cnt
   import wram_ctrl_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic             i_dec,
   input  logic [CNT_W-1:0] i_load_val,
   output logic             o_tc
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_tc = (r_count == CNT_W'(1));

endmodule

// File: rtl/m68k_wram_ctrl.sv
// 68000 bus to dual 32Kx8 SRAM sequencer; every RAM strobe comes straight from a flop.
// Optional write protect is enabled by defining WRAM_WP_EN.
module m68k_wram_ctrl
   import wram_ctrl_pkg::*;
#(
   parameter int WAIT_CYCLES = WRAM_WAIT_DEFAULT
) (
   input  logic        CLK_24M,
   input  logic        nRESET,
   input  logic        nWRAM_SEL,
   input  logic        nAS,
   input  logic        nUDS,
   input  logic        nLDS,
   input  logic        RW,
   input  logic [14:0] M68K_ADDR,
   input  logic [15:0] M68K_DIN,
   output logic [15:0] M68K_DOUT,
   output logic        M68K_DOUT_EN,
   output logic        nDTACK,
   output logic [14:0] RAM_ADDR,
   output logic [15:0] RAM_DOUT,
   output logic        RAM_DOE,
   input  logic [15:0] RAM_DIN,
   output logic        nRAM_CE_U,
   output logic        nRAM_CE_L,
   output logic        nRAM_OE,
   output logic        nRAM_WE,
   input  logic        WP
);

   wram_state_t r_state, w_next;
   logic        w_accept, w_tc, w_load, w_dec;
   logic        w_selU, w_selL, w_wp, w_active, w_wrPhase;
   logic        r_rw, r_selU, r_selL;
   logic        r_nCeU, r_nCeL, r_nOe, r_nWe, r_doe, r_nDtack, r_doutEn;
   logic [14:0] r_addr;
   logic [15:0] r_wdata, r_mdout;

   assign w_accept = (r_state == ST_IDLE) && !nWRAM_SEL && !nAS && (!nUDS || !nLDS);

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:     if (w_accept) w_next = RW ? ST_READ : ST_WR_SETUP;
         ST_READ:     if (nAS) w_next = ST_IDLE; else if (w_tc) w_next = ST_DONE;
         ST_WR_SETUP: w_next = nAS ? ST_IDLE : ST_WR_PULSE;
         ST_WR_PULSE: if (nAS || w_tc) w_next = ST_WR_HOLD;
         ST_WR_HOLD:  w_next = nAS ? ST_IDLE : ST_DONE;
         ST_DONE:     if (nAS) w_next = ST_IDLE;
         default:     w_next = ST_IDLE;
      endcase
   end

   // Reads start timing at the request edge, writes only once setup is over.
   assign w_load = (w_accept && RW) || ((r_state == ST_WR_SETUP) && (w_next == ST_WR_PULSE));
   assign w_dec  = (r_state == ST_READ) || (r_state == ST_WR_PULSE);

   wram_wait_cnt u_waitCnt (
      .i_clk      (CLK_24M),
      .i_rst_n    (nRESET),
      .i_load     (w_load),
      .i_dec      (w_dec),
      .i_load_val (CNT_W'(WAIT_CYCLES)),
      .o_tc       (w_tc)
   );

   assign w_selU    = w_accept ? !nUDS : r_selU;
   assign w_selL    = w_accept ? !nLDS : r_selL;
   assign w_active  = (w_next == ST_READ) || (w_next == ST_WR_SETUP) ||
                      (w_next == ST_WR_PULSE) || (w_next == ST_WR_HOLD);
   assign w_wrPhase = (w_next == ST_WR_SETUP) || (w_next == ST_WR_PULSE) || (w_next == ST_WR_HOLD);

`ifdef WRAM_WP_EN
   logic r_wp;

   always_ff @(posedge CLK_24M or negedge nRESET) begin
      if (!nRESET) begin
         r_wp <= 1'b0;
      end else if (w_accept) begin
         r_wp <= WP;
      end
   end

   assign w_wp = w_accept ? WP : r_wp;
`else
   logic w_unused_wp;

   assign w_unused_wp = WP;
   assign w_wp        = 1'b0;
`endif

   // Strobes are computed from the next state so they change exactly on the clock edge.
   always_ff @(posedge CLK_24M or negedge nRESET) begin
      if (!nRESET) begin
         r_state  <= ST_IDLE;
         r_rw     <= 1'b1;
         r_selU   <= 1'b0;
         r_selL   <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_mdout  <= '0;
         r_nCeU   <= 1'b1;
         r_nCeL   <= 1'b1;
         r_nOe    <= 1'b1;
         r_nWe    <= 1'b1;
         r_doe    <= 1'b0;
         r_nDtack <= 1'b1;
         r_doutEn <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_addr  <= M68K_ADDR;
            r_wdata <= M68K_DIN;
            r_rw    <= RW;
            r_selU  <= !nUDS;
            r_selL  <= !nLDS;
         end
         if ((r_state == ST_READ) && (w_next == ST_DONE)) begin
            r_mdout <= {r_selU ? RAM_DIN[15:8] : 8'h00, r_selL ? RAM_DIN[7:0] : 8'h00};
         end
         r_nCeU   <= !(w_active && w_selU);
         r_nCeL   <= !(w_active && w_selL);
         r_nOe    <= (w_next != ST_READ);
         r_nWe    <= !((w_next == ST_WR_PULSE) && !w_wp);
         r_doe    <= w_wrPhase && !w_wp;
         r_nDtack <= (w_next != ST_DONE);
         r_doutEn <= (w_next == ST_DONE) && r_rw;
      end
   end

   assign M68K_DOUT    = r_mdout;
   assign M68K_DOUT_EN = r_doutEn;
   assign nDTACK       = r_nDtack;
   assign RAM_ADDR     = r_addr;
   assign RAM_DOUT     = r_wdata;
   assign RAM_DOE      = r_doe;
   assign nRAM_CE_U    = r_nCeU;
   assign nRAM_CE_L    = r_nCeL;
   assign nRAM_OE      = r_nOe;
   assign nRAM_WE      = r_nWe;

endmodule

// File: tb/tb_m68k_wram_ctrl.sv
// Bench for m68k_wram_ctrl: SRAM model plus a cycle-level expectation of the 68k bus protocol.
// Write-protect expectations follow WRAM_WP_EN.
module tb_m68k_wram_ctrl;

   localparam int W = 3;
`ifdef WRAM_WP_EN
   localparam bit WP_ON = 1'b1;
`else
   localparam bit WP_ON = 1'b0;
`endif

   logic        CLK_24M = 1'b0;
   logic        nRESET, nWRAM_SEL, nAS, nUDS, nLDS, RW, WP;
   logic [14:0] M68K_ADDR;
   logic [15:0] M68K_DIN, M68K_DOUT, RAM_DOUT, RAM_DIN;
   logic        M68K_DOUT_EN, nDTACK, RAM_DOE;
   logic [14:0] RAM_ADDR;
   logic        nRAM_CE_U, nRAM_CE_L, nRAM_OE, nRAM_WE;

   bit [15:0] sram   [0:32767];
   bit [15:0] refMem [0:32767];
   int total = 0;
   int bad   = 0;

   m68k_wram_ctrl #(.WAIT_CYCLES(W)) dut (
      .CLK_24M(CLK_24M), .nRESET(nRESET), .nWRAM_SEL(nWRAM_SEL), .nAS(nAS),
      .nUDS(nUDS), .nLDS(nLDS), .RW(RW), .M68K_ADDR(M68K_ADDR), .M68K_DIN(M68K_DIN),
      .M68K_DOUT(M68K_DOUT), .M68K_DOUT_EN(M68K_DOUT_EN), .nDTACK(nDTACK),
      .RAM_ADDR(RAM_ADDR), .RAM_DOUT(RAM_DOUT), .RAM_DOE(RAM_DOE), .RAM_DIN(RAM_DIN),
      .nRAM_CE_U(nRAM_CE_U), .nRAM_CE_L(nRAM_CE_L), .nRAM_OE(nRAM_OE), .nRAM_WE(nRAM_WE),
      .WP(WP)
   );

   always #21 CLK_24M = ~CLK_24M;

   // Asynchronous SRAM pair: reads are combinational, writes land on the rising edge of nWE.
   assign RAM_DIN = sram[RAM_ADDR];

   always @(posedge nRAM_WE) begin
      if (nRESET && RAM_DOE) begin
         if (!nRAM_CE_U) sram[RAM_ADDR][15:8] <= RAM_DOUT[15:8];
         if (!nRAM_CE_L) sram[RAM_ADDR][7:0]  <= RAM_DOUT[7:0];
      end
   end

   always @(negedge CLK_24M) begin
      if (nRESET) begin
         total++;
         if ((!nRAM_OE && !nRAM_WE) || (RAM_DOE && !nRAM_OE)) begin
            bad++;
            $display("[TB] FAIL strobeInvariant oe=%b we=%b doe=%b", nRAM_OE, nRAM_WE, RAM_DOE);
         end
      end
   end

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog");
   end

   task automatic releaseBus();
      nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1; nWRAM_SEL = 1'b1; RW = 1'b1;
   endtask

   // One 68k bus cycle; abortAt >= 0 raises nAS after that sample, otherwise nAS rises after DTACK.
   task automatic applyStimulus(input bit rw, input bit uds, input bit lds, input logic [14:0] addr,
                                input logic [15:0] data, input bit wp, input int abortAt);
      bit abort, wpEff, busy;
      bit eCeU, eCeL, eOe, eWe, eDoe, eDtack, eEn;
      int ceEnd, weEnd, dtC, dropAt, lastC;
      logic [15:0] expRd;
      abort = (abortAt >= 0);
      wpEff = WP_ON && wp;
      dtC   = -1;
      weEnd = 0;
      if (rw) begin
         ceEnd = abort ? abortAt : W - 1;
         if (!abort) dtC = W;
      end else if (!abort) begin
         ceEnd = W + 1; weEnd = W; dtC = W + 2;
      end else if (abortAt == 0) begin
         ceEnd = 0;
      end else begin
         ceEnd = abortAt + 1; weEnd = abortAt;
      end
      if (wpEff) weEnd = 0;
      dropAt = abort ? abortAt : dtC;
      lastC  = (!rw && abort && abortAt > 0) ? dropAt + 2 : dropAt + 1;
      expRd  = {uds ? refMem[addr][15:8] : 8'h00, lds ? refMem[addr][7:0] : 8'h00};

      nWRAM_SEL = 1'b0; nAS = 1'b0; nUDS = !uds; nLDS = !lds; RW = rw;
      M68K_ADDR = addr; M68K_DIN = data; WP = wp;
      @(posedge CLK_24M);
      for (int c = 0; c <= lastC; c++) begin
         @(negedge CLK_24M);
         busy   = (c <= ceEnd);
         eCeU   = !(busy && uds);
         eCeL   = !(busy && lds);
         eOe    = !(rw && busy);
         eWe    = !((c >= 1) && (c <= weEnd));
         eDoe   = !rw && busy && !wpEff;
         eDtack = (c != dtC);
         eEn    = rw && (c == dtC);
         total += 7;
         if (nRAM_CE_U !== eCeU) begin bad++; $display("[TB] FAIL ceU c=%0d got=%b exp=%b", c, nRAM_CE_U, eCeU); end
         if (nRAM_CE_L !== eCeL) begin bad++; $display("[TB] FAIL ceL c=%0d got=%b exp=%b", c, nRAM_CE_L, eCeL); end
         if (nRAM_OE !== eOe) begin bad++; $display("[TB] FAIL oe c=%0d got=%b exp=%b", c, nRAM_OE, eOe); end
         if (nRAM_WE !== eWe) begin bad++; $display("[TB] FAIL we c=%0d got=%b exp=%b", c, nRAM_WE, eWe); end
         if (RAM_DOE !== eDoe) begin bad++; $display("[TB] FAIL doe c=%0d got=%b exp=%b", c, RAM_DOE, eDoe); end
         if (nDTACK !== eDtack) begin bad++; $display("[TB] FAIL dtack c=%0d got=%b exp=%b", c, nDTACK, eDtack); end
         if (M68K_DOUT_EN !== eEn) begin bad++; $display("[TB] FAIL doutEn c=%0d got=%b exp=%b", c, M68K_DOUT_EN, eEn); end
         if (busy) begin
            total++;
            if (RAM_ADDR !== addr) begin bad++; $display("[TB] FAIL ramAddr c=%0d got=%h exp=%h", c, RAM_ADDR, addr); end
            if (!rw) begin
               total++;
               if (RAM_DOUT !== data) begin bad++; $display("[TB] FAIL ramDout c=%0d got=%h exp=%h", c, RAM_DOUT, data); end
            end
         end
         if (rw && (c == dtC)) begin
            total++;
            if (M68K_DOUT !== expRd) begin bad++; $display("[TB] FAIL readData a=%h got=%h exp=%h", addr, M68K_DOUT, expRd); end
         end
         if (c == dropAt) releaseBus();
      end
      if (!rw && !abort && !wpEff) begin
         if (uds) refMem[addr][15:8] = data[15:8];
         if (lds) refMem[addr][7:0]  = data[7:0];
      end
   endtask

   task automatic checkOutput(input string name);
      total += 4;
      if ({nRAM_CE_U, nRAM_CE_L, nRAM_OE, nRAM_WE, nDTACK, RAM_DOE, M68K_DOUT_EN} !== 7'b1111100) begin
         bad++;
         $display("[TB] FAIL %s strobes got=%b exp=1111100", name,
                  {nRAM_CE_U, nRAM_CE_L, nRAM_OE, nRAM_WE, nDTACK, RAM_DOE, M68K_DOUT_EN});
      end
      if (M68K_DOUT !== 16'h0) begin bad++; $display("[TB] FAIL %s doutReset got=%h exp=0000", name, M68K_DOUT); end
      if (RAM_ADDR !== 15'h0) begin bad++; $display("[TB] FAIL %s addrReset got=%h exp=0000", name, RAM_ADDR); end
      if (RAM_DOUT !== 16'h0) begin bad++; $display("[TB] FAIL %s ramDoutReset got=%h exp=0000", name, RAM_DOUT); end
   endtask

   task automatic test_reset();
      nRESET = 1'b0;
      releaseBus();
      M68K_ADDR = '0; M68K_DIN = '0; WP = 1'b0;
      repeat (3) @(negedge CLK_24M);
      checkOutput("resetHeld");
      nRESET = 1'b1;
      repeat (2) @(negedge CLK_24M);
      checkOutput("afterReset");
   endtask

   task automatic test_word_read();
      applyStimulus(1'b0, 1'b1, 1'b1, 15'h0123, 16'hA55A, 1'b0, -1);
      applyStimulus(1'b1, 1'b1, 1'b1, 15'h0123, 16'h0000, 1'b0, -1);
   endtask

   task automatic test_upper_write();
      applyStimulus(1'b0, 1'b1, 1'b0, 15'h7FFF, 16'hBEEF, 1'b0, -1);
      total++;
      if (sram[15'h7FFF] !== 16'hBE00) begin bad++; $display("[TB] FAIL upperWriteMem got=%h exp=be00", sram[15'h7FFF]); end
      applyStimulus(1'b1, 1'b1, 1'b1, 15'h7FFF, 16'h0000, 1'b0, -1);
   endtask

   task automatic test_reset_mid_read();
      nWRAM_SEL = 1'b0; nAS = 1'b0; nUDS = 1'b0; nLDS = 1'b0; RW = 1'b1;
      M68K_ADDR = 15'h0555; M68K_DIN = 16'h3C3C;
      @(posedge CLK_24M);
      @(negedge CLK_24M);
      total++;
      if (nRAM_OE !== 1'b0) begin bad++; $display("[TB] FAIL midReadOe got=%b exp=0", nRAM_OE); end
      #5 nRESET = 1'b0;
      #1 checkOutput("asyncReset");
      releaseBus();
      @(negedge CLK_24M);
      nRESET = 1'b1;
      @(negedge CLK_24M);
      applyStimulus(1'b1, 1'b1, 1'b1, 15'h0123, 16'h0000, 1'b0, -1);
   endtask

   task automatic test_abort();
      applyStimulus(1'b0, 1'b1, 1'b1, 15'h0200, 16'h1111, 1'b0, 2);
      applyStimulus(1'b0, 1'b1, 1'b1, 15'h0201, 16'h2222, 1'b0, 0);
      applyStimulus(1'b1, 1'b1, 1'b1, 15'h0123, 16'h0000, 1'b0, 1);
      applyStimulus(1'b1, 1'b1, 1'b1, 15'h0123, 16'h0000, 1'b0, -1);
   endtask

   task automatic test_write_protect();
      logic [15:0] expMem;
      expMem = WP_ON ? sram[15'h0300] : 16'h1234;
      applyStimulus(1'b0, 1'b1, 1'b1, 15'h0300, 16'h1234, 1'b1, -1);
      total++;
      if (sram[15'h0300] !== expMem) begin bad++; $display("[TB] FAIL wpMem got=%h exp=%h", sram[15'h0300], expMem); end
      applyStimulus(1'b1, 1'b1, 1'b1, 15'h0300, 16'h0000, 1'b0, -1);
   endtask

   task automatic test_back_to_back();
      applyStimulus(1'b0, 1'b0, 1'b1, 15'h0400, 16'h5A00 | 16'h00C3, 1'b0, -1);
      applyStimulus(1'b0, 1'b1, 1'b0, 15'h0400, 16'h7E00, 1'b0, -1);
      applyStimulus(1'b1, 1'b1, 1'b1, 15'h0400, 16'h0000, 1'b0, -1);
      applyStimulus(1'b1, 1'b0, 1'b1, 15'h0400, 16'h0000, 1'b0, -1);
   endtask

   task automatic test_random_traffic();
      bit rw, wp;
      logic [1:0] lanes;
      logic [14:0] addr;
      logic [15:0] data;
      for (int i = 0; i < 40; i++) begin
         rw    = 1'($urandom_range(0, 1));
         lanes = 2'($urandom_range(1, 3));
         addr  = 15'h4000 + 15'($urandom_range(0, 7));
         data  = 16'($urandom);
         wp    = ($urandom_range(0, 3) == 0);
         applyStimulus(rw, lanes[1], lanes[0], addr, data, wp, -1);
      end
   endtask

   initial begin
      test_reset();
      test_word_read();
      test_upper_write();
      test_reset_mid_read();
      test_abort();
      test_write_protect();
      test_back_to_back();
      test_random_traffic();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
